// File: rtl/digit_serial_adder_if.sv
// rtl/digit_serial_adder_if.sv - request/result bundle for the digit-serial adder
interface digit_serial_adder_if #(
    parameter int WIDTH = 8
);
    logic             start;
    logic [WIDTH-1:0] a;
    logic [WIDTH-1:0] b;
    logic             cin;
    logic             busy;
    logic             done;
    logic [WIDTH-1:0] sum;
    logic             cout;
    logic             ovf;

    modport master (
        output start,
        output a,
        output b,
        output cin,
        input  busy,
        input  done,
        input  sum,
        input  cout,
        input  ovf
    );

    modport slave (
        input  start,
        input  a,
        input  b,
        input  cin,
        output busy,
        output done,
        output sum,
        output cout,
        output ovf
    );
endinterface

// File: rtl/digit_serial_adder.sv
// rtl/digit_serial_adder.sv - LSB-first digit-serial adder with carry and overflow flags
module digit_serial_adder #(
    parameter int WIDTH = 8,
    parameter int DIGIT = 1
) (
    input  logic               clk,
    input  logic               rst,
    digit_serial_adder_if.slave bus
);
    localparam int N  = WIDTH / DIGIT;
    localparam int CW = $clog2(N + 1);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RUN  = 2'd1,
        DONE = 2'd2
    } state_t;

    state_t state;
    state_t state_nxt;

    logic [WIDTH-1:0] a_sh;
    logic [WIDTH-1:0] b_sh;
    logic [WIDTH-1:0] psum;
    logic             carry;
    logic [CW-1:0]    cnt;

    logic [WIDTH-1:0] sum_q;
    logic             cout_q;
    logic             ovf_q;

    logic [DIGIT-1:0] a_dig;
    logic [DIGIT-1:0] b_dig;
    logic [DIGIT:0]   dsum;
    logic             msb_cin;
    logic             last_digit;
    logic [WIDTH-1:0] a_nxt;
    logic [WIDTH-1:0] b_nxt;
    logic [WIDTH-1:0] psum_nxt;

    assign a_dig      = a_sh[DIGIT-1:0];
    assign b_dig      = b_sh[DIGIT-1:0];
    assign last_digit = (cnt == CW'(N - 1));

    // Add the current low digit of both operands plus the running carry
    always_comb begin
        dsum    = {1'b0, a_dig} + {1'b0, b_dig} + {{DIGIT{1'b0}}, carry};
        // Carry into the top bit of this digit; only meaningful on the final digit,
        // where that top bit is the word MSB.
        msb_cin = dsum[DIGIT-1] ^ a_dig[DIGIT-1] ^ b_dig[DIGIT-1];
    end

    // Shift operands right and the partial sum in from the MSB side; a full-width
    // digit has nothing left to shift, so it gets its own branch.
    generate
        if (DIGIT == WIDTH) begin : g_single
            always_comb begin
                a_nxt    = '0;
                b_nxt    = '0;
                psum_nxt = dsum[DIGIT-1:0];
            end
        end else begin : g_multi
            always_comb begin
                a_nxt    = {{DIGIT{1'b0}}, a_sh[WIDTH-1:DIGIT]};
                b_nxt    = {{DIGIT{1'b0}}, b_sh[WIDTH-1:DIGIT]};
                psum_nxt = {dsum[DIGIT-1:0], psum[WIDTH-1:DIGIT]};
            end
        end
    endgenerate

    // State register
    always_ff @(posedge clk) begin
        if (rst) begin
            state <= IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    // Next-state logic: start only matters in IDLE, DONE always falls back to IDLE
    always_comb begin
        state_nxt = state;
        case (state)
            IDLE: begin
                if (bus.start) begin
                    state_nxt = RUN;
                end
            end
            RUN: begin
                if (last_digit) begin
                    state_nxt = DONE;
                end
            end
            DONE: begin
                state_nxt = IDLE;
            end
            default: begin
                state_nxt = IDLE;
            end
        endcase
    end

    // Datapath: capture on accept, one digit per RUN cycle, results loaded on the last digit
    always_ff @(posedge clk) begin
        if (rst) begin
            a_sh   <= '0;
            b_sh   <= '0;
            psum   <= '0;
            carry  <= 1'b0;
            cnt    <= '0;
            sum_q  <= '0;
            cout_q <= 1'b0;
            ovf_q  <= 1'b0;
        end else begin
            case (state)
                IDLE: begin
                    if (bus.start) begin
                        a_sh  <= bus.a;
                        b_sh  <= bus.b;
                        carry <= bus.cin;
                        psum  <= '0;
                        cnt   <= '0;
                    end
                end
                RUN: begin
                    a_sh  <= a_nxt;
                    b_sh  <= b_nxt;
                    psum  <= psum_nxt;
                    carry <= dsum[DIGIT];
                    cnt   <= cnt + CW'(1);
                    if (last_digit) begin
                        sum_q  <= psum_nxt;
                        cout_q <= dsum[DIGIT];
                        ovf_q  <= dsum[DIGIT] ^ msb_cin;
                    end
                end
                default: begin
                end
            endcase
        end
    end

    assign bus.busy = (state != IDLE);
    assign bus.done = (state == DONE);
    assign bus.sum  = sum_q;
    assign bus.cout = cout_q;
    assign bus.ovf  = ovf_q;

endmodule

// File: tb/tb_digit_serial_adder.sv
// tb/tb_digit_serial_adder.sv - randomized and directed bench for digit_serial_adder
module tb_digit_serial_adder;
    logic clk = 1'b0;
    logic rst = 1'b1;

    always #5 clk = ~clk;

    // Per-instance stimulus/observation, indexed 0..4:
    // 0: 8/1, 1: 8/2, 2: 8/4, 3: 8/8, 4: 16/4
    logic [4:0]  start_v = '0;
    logic [4:0]  cin_v   = '0;
    logic [15:0] a_v [5];
    logic [15:0] b_v [5];
    logic [4:0]  busy_w;
    logic [4:0]  done_w;
    logic [4:0]  cout_w;
    logic [4:0]  ovf_w;
    logic [15:0] sum_w [5];

    int n_tests = 0;
    int n_fail  = 0;

    digit_serial_adder_if #(.WIDTH(8))  if0 ();
    digit_serial_adder_if #(.WIDTH(8))  if1 ();
    digit_serial_adder_if #(.WIDTH(8))  if2 ();
    digit_serial_adder_if #(.WIDTH(8))  if3 ();
    digit_serial_adder_if #(.WIDTH(16)) if4 ();

    digit_serial_adder #(.WIDTH(8),  .DIGIT(1)) u0 (.clk(clk), .rst(rst), .bus(if0.slave));
    digit_serial_adder #(.WIDTH(8),  .DIGIT(2)) u1 (.clk(clk), .rst(rst), .bus(if1.slave));
    digit_serial_adder #(.WIDTH(8),  .DIGIT(4)) u2 (.clk(clk), .rst(rst), .bus(if2.slave));
    digit_serial_adder #(.WIDTH(8),  .DIGIT(8)) u3 (.clk(clk), .rst(rst), .bus(if3.slave));
    digit_serial_adder #(.WIDTH(16), .DIGIT(4)) u4 (.clk(clk), .rst(rst), .bus(if4.slave));

    assign if0.start = start_v[0]; assign if0.cin = cin_v[0];
    assign if0.a = a_v[0][7:0];    assign if0.b = b_v[0][7:0];
    assign if1.start = start_v[1]; assign if1.cin = cin_v[1];
    assign if1.a = a_v[1][7:0];    assign if1.b = b_v[1][7:0];
    assign if2.start = start_v[2]; assign if2.cin = cin_v[2];
    assign if2.a = a_v[2][7:0];    assign if2.b = b_v[2][7:0];
    assign if3.start = start_v[3]; assign if3.cin = cin_v[3];
    assign if3.a = a_v[3][7:0];    assign if3.b = b_v[3][7:0];
    assign if4.start = start_v[4]; assign if4.cin = cin_v[4];
    assign if4.a = a_v[4];         assign if4.b = b_v[4];

    assign busy_w = {if4.busy, if3.busy, if2.busy, if1.busy, if0.busy};
    assign done_w = {if4.done, if3.done, if2.done, if1.done, if0.done};
    assign cout_w = {if4.cout, if3.cout, if2.cout, if1.cout, if0.cout};
    assign ovf_w  = {if4.ovf,  if3.ovf,  if2.ovf,  if1.ovf,  if0.ovf};
    assign sum_w[0] = 16'(if0.sum);
    assign sum_w[1] = 16'(if1.sum);
    assign sum_w[2] = 16'(if2.sum);
    assign sum_w[3] = 16'(if3.sum);
    assign sum_w[4] = if4.sum;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_tests++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    // Called just after a sample point; walks forward one cycle at a time until done
    task automatic wait_done(input int k, input int n, input int lat0,
                             output int lat, output int busy_n, output bit seen);
        lat    = lat0;
        busy_n = 0;
        seen   = 1'b0;
        for (int i = 0; i < n + 4 && !seen; i++) begin
            if (busy_w[k]) busy_n++;
            if (done_w[k]) begin
                seen = 1'b1;
            end else begin
                @(negedge clk);
                lat++;
            end
        end
    endtask

    // One complete operation checked against plain integer arithmetic.
    // Latency counts clock edges from the accepting edge through the edge that raises done.
    task automatic run_op(input int k, input int w, input int n,
                          input logic [15:0] a, input logic [15:0] b, input logic ci,
                          input string tag);
        logic [16:0] full;
        logic [15:0] mask;
        logic [15:0] am;
        logic [15:0] bm;
        logic [15:0] es;
        logic        ec;
        logic        eo;
        int          lat;
        int          busy_n;
        bit          seen;
        mask = 16'((17'd1 << w) - 17'd1);
        am   = a & mask;
        bm   = b & mask;
        full = 17'(am) + 17'(bm) + 17'(ci);
        es   = full[15:0] & mask;
        ec   = full[w];
        eo   = (am[w-1] == bm[w-1]) && (es[w-1] != am[w-1]);

        a_v[k] = a; b_v[k] = b; cin_v[k] = ci; start_v[k] = 1'b1;
        @(negedge clk);
        start_v[k] = 1'b0;
        a_v[k] = 16'($urandom); b_v[k] = 16'($urandom); cin_v[k] = 1'($urandom);
        wait_done(k, n, 1, lat, busy_n, seen);
        check({tag, "_done_seen"}, 32'(seen), 32'd1);
        check({tag, "_latency"}, 32'(lat), 32'(n + 1));
        check({tag, "_busy_cycles"}, 32'(busy_n), 32'(n + 1));
        check({tag, "_sum"}, 32'(sum_w[k]), 32'(es));
        check({tag, "_cout"}, 32'(cout_w[k]), 32'(ec));
        check({tag, "_ovf"}, 32'(ovf_w[k]), 32'(eo));
        @(negedge clk);
        check({tag, "_done_pulse"}, 32'(done_w[k]), 32'd0);
        check({tag, "_idle_busy"}, 32'(busy_w[k]), 32'd0);
    endtask

    task automatic check_cleared(input int k, input string tag);
        check({tag, "_busy"}, 32'(busy_w[k]), 32'd0);
        check({tag, "_done"}, 32'(done_w[k]), 32'd0);
        check({tag, "_sum"},  32'(sum_w[k]),  32'd0);
        check({tag, "_cout"}, 32'(cout_w[k]), 32'd0);
        check({tag, "_ovf"},  32'(ovf_w[k]),  32'd0);
    endtask

    initial begin
        int ws [5];
        int ns [5];
        int lat;
        int busy_n;
        int done_cnt;
        bit seen;
        logic [15:0] ra;
        logic [15:0] rb;
        logic        rc;

        ws = '{8, 8, 8, 8, 16};
        ns = '{8, 4, 2, 1, 4};
        for (int k = 0; k < 5; k++) begin
            a_v[k] = '0;
            b_v[k] = '0;
        end

        // Reset state
        repeat (3) @(negedge clk);
        for (int k = 0; k < 5; k++) check_cleared(k, "reset");

        // First start accepted on the very first edge with rst low
        rst = 1'b0;
        run_op(0, 8, 8, 16'h00FF, 16'h0001, 1'b0, "ff_plus_1");
        check("ff_plus_1_hold_sum", 32'(sum_w[0]), 32'h00);
        check("ff_plus_1_hold_cout", 32'(cout_w[0]), 32'd1);
        check("ff_plus_1_hold_ovf", 32'(ovf_w[0]), 32'd0);

        run_op(0, 8, 8, 16'h007F, 16'h0001, 1'b0, "7f_plus_1");
        check("7f_plus_1_sum_const", 32'(sum_w[0]), 32'h80);
        check("7f_plus_1_ovf_const", 32'(ovf_w[0]), 32'd1);
        run_op(0, 8, 8, 16'h0080, 16'h0080, 1'b0, "80_plus_80");
        check("80_plus_80_cout_const", 32'(cout_w[0]), 32'd1);
        check("80_plus_80_ovf_const", 32'(ovf_w[0]), 32'd1);

        run_op(2, 8, 2, 16'h00A5, 16'h005A, 1'b1, "a5_5a_d4");
        check("a5_5a_d4_sum_const", 32'(sum_w[2]), 32'h00);
        check("a5_5a_d4_cout_const", 32'(cout_w[2]), 32'd1);

        // start re-pulsed during RUN and DONE is ignored; start in the next IDLE is taken
        a_v[0] = 16'h0033; b_v[0] = 16'h0044; cin_v[0] = 1'b0; start_v[0] = 1'b1;
        @(negedge clk);
        a_v[0] = 16'h00F0; b_v[0] = 16'h000F; cin_v[0] = 1'b1;
        @(negedge clk);
        start_v[0] = 1'b0;
        wait_done(0, 8, 2, lat, busy_n, seen);
        check("repulse_done_seen", 32'(seen), 32'd1);
        check("repulse_latency", 32'(lat), 32'd9);
        check("repulse_sum", 32'(sum_w[0]), 32'h77);
        a_v[0] = 16'h0011; b_v[0] = 16'h0022; cin_v[0] = 1'b0; start_v[0] = 1'b1;
        @(negedge clk);
        check("repulse_no_second_done", 32'(done_w[0]), 32'd0);
        check("repulse_idle_busy", 32'(busy_w[0]), 32'd0);
        check("repulse_hold_sum", 32'(sum_w[0]), 32'h77);
        @(negedge clk);
        start_v[0] = 1'b0;
        check("idle_accept_busy", 32'(busy_w[0]), 32'd1);
        wait_done(0, 8, 1, lat, busy_n, seen);
        check("idle_accept_latency", 32'(lat), 32'd9);
        check("idle_accept_sum", 32'(sum_w[0]), 32'h33);
        @(negedge clk);

        // Reset during the 3rd RUN cycle aborts with no done pulse
        run_op(0, 8, 8, 16'h0080, 16'h0081, 1'b0, "pre_abort");
        a_v[0] = 16'h0055; b_v[0] = 16'h000F; cin_v[0] = 1'b0; start_v[0] = 1'b1;
        @(negedge clk);
        start_v[0] = 1'b0;
        @(negedge clk);
        @(negedge clk);
        rst = 1'b1;
        @(negedge clk);
        rst = 1'b0;
        check_cleared(0, "abort");
        done_cnt = 0;
        repeat (12) begin
            if (done_w[0]) done_cnt++;
            @(negedge clk);
        end
        check("abort_no_done", 32'(done_cnt), 32'd0);
        run_op(0, 8, 8, 16'h0055, 16'h000F, 1'b0, "post_abort");

        // Random regression across all parameter sets
        for (int k = 0; k < 5; k++) begin
            for (int i = 0; i < 1000; i++) begin
                if ($urandom_range(0, 7) == 0) begin
                    ra = 16'hFFFF;
                    rb = 16'h0000;
                    rc = 1'b1;
                end else begin
                    ra = 16'($urandom);
                    rb = 16'($urandom);
                    rc = 1'($urandom);
                end
                run_op(k, ws[k], ns[k], ra, rb, rc, "rand");
            end
        end

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end
endmodule
